// File: rtl/sdm_stream_decoder_if.sv
// Sample-stream and result-handshake bundle for the sigma-delta stream decoder.
// master: sample source / result consumer; slave: the decoder.
interface sdm_stream_decoder_if #(
  parameter int unsigned N_FRAC = 26
);
  logic            en;
  logic            frac;
  logic            clr;
  logic [N_FRAC:0] alpha_est;
  logic            out_valid;
  logic            out_ready;
  logic            overrun;
  logic            settled;

  modport master (
    output en, frac, clr, out_ready,
    input  alpha_est, out_valid, overrun, settled
  );

  modport slave (
    input  en, frac, clr, out_ready,
    output alpha_est, out_valid, overrun, settled
  );
endinterface

// File: rtl/sdm_stream_decoder.sv
// Sinc^2 (2nd-order CIC) decimator recovering alpha from the 1-bit frac stream,
// with a valid/ready result register and sticky overrun flag.
module sdm_stream_decoder #(
  parameter int unsigned N_FRAC   = 26,
  parameter int unsigned LOG2_DEC = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  sdm_stream_decoder_if.slave bus
);

  localparam int unsigned B     = 2 * LOG2_DEC + 1;
  localparam int unsigned SHIFT = N_FRAC - 2 * LOG2_DEC;

  typedef enum logic [1:0] {
    SET_PRIME,  // waiting for the first (discarded) result
    SET_FILL,   // first result discarded, next one is delivered
    SET_RUN     // delivering results
  } settle_t;

  settle_t             settle_q, settle_d;
  logic [B-1:0]        i1, i2, c1d, c2d;
  logic [LOG2_DEC-1:0] dcnt;
  logic [N_FRAC:0]     alpha_q;
  logic                valid_q, overrun_q;

  logic [B-1:0]        i1_nx, i2_nx, d1, y;
  logic [N_FRAC:0]     y_scaled;
  logic                accept, dec_edge, load;

  always_comb begin
    accept   = bus.en & ~bus.clr;
    i1_nx    = i1 + B'(bus.frac);
    i2_nx    = i2 + i1_nx;
    dec_edge = accept && (dcnt == '1);
    d1       = i2_nx - c2d;
    y        = d1 - c1d;
    y_scaled = (N_FRAC+1)'(y) << SHIFT;
    load     = dec_edge && (settle_q != SET_PRIME);
  end

  always_comb begin
    settle_d = settle_q;
    if (bus.clr) begin
      settle_d = SET_PRIME;
    end else if (dec_edge) begin
      unique case (settle_q)
        SET_PRIME: settle_d = SET_FILL;
        SET_FILL:  settle_d = SET_RUN;
        default:   settle_d = SET_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settle_q <= SET_PRIME;
    else        settle_q <= settle_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1        <= '0;
      i2        <= '0;
      c1d       <= '0;
      c2d       <= '0;
      dcnt      <= '0;
      alpha_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.clr) begin
      // alpha_est deliberately survives clr
      i1        <= '0;
      i2        <= '0;
      c1d       <= '0;
      c2d       <= '0;
      dcnt      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        i1   <= i1_nx;
        i2   <= i2_nx;
        dcnt <= dcnt + LOG2_DEC'(1);
        if (dec_edge) begin
          c2d <= i2_nx;
          c1d <= d1;
        end
      end
      if (load) begin
        alpha_q <= y_scaled;
        valid_q <= 1'b1;
        if (valid_q && !bus.out_ready) overrun_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.alpha_est = alpha_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.settled   = (settle_q == SET_RUN);

endmodule

// File: doc/sdm_stream_decoder.md
Name: sdm_stream_decoder

Overview:
- Receive end of the sigma-delta → divider interface: consumes the 1-bit `frac` stream that selects N/N+1 in the divider, and recovers the fractional word `alpha`.
- Clocked by the divided clock (ClK_Div domain). Used for closed-loop checking of the modulator and for lock monitoring.
- Sinc² (2nd-order CIC) decimator, decimation 2^LOG2_DEC, with a valid/ready output register and a sticky overrun flag.

Parameters:
- N_FRAC, 26, fractional width of alpha; full-scale density 1.0 = 2^N_FRAC.
- LOG2_DEC, 10, log2 of decimation ratio W; legal range 1..N_FRAC/2.

Ports:
- clk  in  1  divided clock (ClK_Div); all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample qualifier; `frac` accepted only on edges with en=1.
- frac  in  1  sigma-delta output bit (1 = divide by N+1).
- clr  in  1  synchronous clear of datapath; has priority over en.
- alpha_est  out  N_FRAC+1  unsigned recovered alpha (frac density × 2^N_FRAC).
- out_valid  out  1  alpha_est holds an unconsumed result.
- out_ready  in  1  consumer accepts alpha_est when out_valid=1.
- overrun  out  1  sticky; a result was lost.
- settled  out  1  1 once the first full sinc² result has been produced.

Behaviour:
- **Reset (rst_n=0, async):**
  - integrators I1, I2 = 0; comb delays C1d, C2d = 0; sample counter dcnt = 0; settle count = 0.
  - alpha_est = 0; out_valid = 0; overrun = 0; settled = 0.
- **Internal width:** B = 2·LOG2_DEC+1 bits for I1, I2, C1d, C2d. All add/subtract wrap modulo 2^B. Wrap is intentional and exact for CIC; no saturation.
- **Accepted sample (en=1, clr=0):**
  - I1 ← I1 + frac.
  - I2 ← I2 + I1_next (I2 integrates the updated I1).
  - dcnt ← dcnt+1, wrapping at W-1 → 0.
- **Decimation edge** (accepted sample with dcnt == W-1):
  - d1 = I2_next − C2d; C2d ← I2_next.
  - y = d1 − C1d; C1d ← d1.
  - y is an unsigned 0..W², registered as the new result on this same edge.
  - alpha_est is loaded with y << (N_FRAC − 2·LOG2_DEC).
  - Latency: alpha_est and out_valid update on the edge that accepts the W-th sample of the window.
- **Settling:**
  - The first decimation result after reset or clr is discarded: no load, out_valid unaffected.
  - The second and later results are delivered, so the first valid result needs 2W accepted samples.
  - settled is set on the first delivered result and stays set until reset or clr.
- **Handshake:**
  - Transfer occurs on an edge with out_valid & out_ready; out_valid then drops unless a new result loads on the same edge.
  - New result while out_valid=1 and out_ready=0: overwrite alpha_est, keep out_valid=1, set overrun.
  - New result on an edge with out_valid & out_ready: load the new value, out_valid stays 1, no overrun.
  - alpha_est holds its value after transfer.
- **en=0:** no state change, except the handshake still operates.
- **clr=1:** the following take the reset value on the next edge, even mid-window:
  - I1, I2, C1d, C2d, dcnt, settle count;
  - out_valid, overrun, settled.
  - alpha_est is not cleared.
- **Range:** all-ones stream gives y = W² → alpha_est = 2^N_FRAC, which fits N_FRAC+1 bits. Any stream periodic with period dividing W gives an exact, constant result.

Test Plan (LOG2_DEC=4 so W=16, N_FRAC=26, en=1, out_ready=1 unless stated):
- Reset, then frac constant 0 for 64 samples → first out_valid on sample 32, alpha_est=0, settled=1 from sample 32, valid pulse every 16 samples.
- Repeating pattern 1,0,0,0 (alpha=2^24 density) → every delivered alpha_est = 16777216, overrun=0.
- Alternating 1,0 → alpha_est = 33554432; all-ones → alpha_est = 67108864 (no width overflow).
- out_ready=0 over 3 decimation edges with the 1,0,0,0 stream → out_valid stays 1, overrun=1 after the 2nd result, alpha_est = 16777216. Then out_ready=1 → out_valid drops next edge, overrun stays 1 until clr.
- en toggled 50% with the 1,0,0,0 pattern applied to accepted samples only → identical values, results every 32 clocks. rst_n pulsed low mid-edge asynchronously → all outputs 0 immediately.
- clr asserted at sample 20 → settled=0, out_valid=0. Next valid output arrives 32 accepted samples after clr deasserts. Run against the modulator with alpha=2^24+DLF_out, DLF_out = 1000 (averaged over 64 results) → mean alpha_est within ±2^(N_FRAC−8) of 16778216.
